mage_div_arbiter: RTL and testbench
===================================

Name: mage_div_arbiter

Overview:
- Shares one multi-cycle divider functional unit between NUM_REQ requesting PEs. Only one operation is in flight at a time.
- Selects the next requester round-robin, using a rotated request mask and a find-first-one priority encoder. It then issues the operands, waits for completion and returns the result to the granted requester over a valid/ready handshake.
- Sits between the PE division ports and the shared divider in the execute stage.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_W, 32, operand/result width.
- ID_W, $clog2(NUM_REQ), width of grant index.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  synchronous reset, active-high.
- req_valid_i  in  NUM_REQ  per-requester operation request.
- req_ready_o  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_op_a_i  in  NUM_REQ x DATA_W  dividend per requester.
- req_op_b_i  in  NUM_REQ x DATA_W  divisor per requester.
- req_signed_i  in  NUM_REQ  signed-operation flag per requester.
- rsp_valid_o  out  NUM_REQ  result valid; one-hot or zero.
- rsp_ready_i  in  NUM_REQ  per-requester result accept.
- rsp_quot_o  out  DATA_W  quotient, broadcast to all requesters.
- rsp_rem_o  out  DATA_W  remainder, broadcast to all requesters.
- div_valid_o  out  1  operation issue to divider.
- div_ready_i  in  1  divider accepts issue.
- div_op_a_o  out  DATA_W  registered dividend.
- div_op_b_o  out  DATA_W  registered divisor.
- div_signed_o  out  1  registered signed flag.
- div_done_i  in  1  single-cycle pulse: divider result valid.
- div_quot_i  in  DATA_W  divider quotient.
- div_rem_i  in  DATA_W  divider remainder.
- busy_o  out  1  high in any state other than IDLE.
- grant_id_o  out  ID_W  index of current/last granted requester.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Reset values: state=IDLE; every output 0; last_grant=NUM_REQ-1, so requester 0 has top priority after reset.
- Arbitration (IDLE only):
  - hi_mask = req_valid_i & bits above last_grant.
  - If hi_mask is nonzero, grant = first one of hi_mask; otherwise grant = first one of req_valid_i (wrap-around).
  - No request: stay in IDLE, req_ready_o=0.
- IDLE with any request:
  - req_ready_o[grant]=1 combinationally in the same cycle.
  - Operands and signed flag of grant are captured, grant_id_o=grant, next state ISSUE.
  - Acceptance latency is 0 cycles from valid when idle.
- ISSUE:
  - div_valid_o=1, operands held stable until div_ready_i=1; then next state WAIT.
  - div_done_i is ignored in ISSUE.
- WAIT:
  - On div_done_i, capture div_quot_i/div_rem_i into the result registers; next state RESP.
  - Must also accept div_done_i in the cycle immediately after the issue handshake.
- RESP:
  - rsp_valid_o[grant_id_o]=1; rsp_quot_o/rsp_rem_o hold the captured values.
  - On rsp_ready_i[grant_id_o]: last_grant <= grant_id_o, next state IDLE.
  - rsp_ready_i of non-granted ports is ignored.
  - Result holds indefinitely under back-pressure.
- Throughput: one operation per (issue + divider latency + response) cycles; no overlap. The earliest new grant is the cycle after the response handshake.
- Request changes:
  - A req_valid_i that drops before grant is simply not considered.
  - Requests arriving during ISSUE/WAIT/RESP wait for IDLE.
- Divide-by-zero and overflow: results pass through unchanged from the divider; no special handling.
- Reset mid-operation:
  - Any state returns to IDLE and last_grant resets.
  - In-flight divider results are discarded; a div_done_i arriving in IDLE is ignored.
- rsp_quot_o/rsp_rem_o keep their last values outside RESP (reset to 0).
- grant_id_o persists after RESP until the next grant.
- The find-first-one encoder's no-ones output gates the grant: no grant and no ready when all requests are low.

Test Plan:
- Single request: req_valid_i=0001, a=100, b=7, unsigned.
  - Required: req_ready_o=0001 the same cycle.
  - div_op_a_o=100, div_op_b_o=7.
  - After div_done_i with quot 14 / rem 2: rsp_valid_o=0001, rsp_quot_o=14, rsp_rem_o=2.
- All four requesting continuously after reset -> grants 0,1,2,3,0 in order. grant_id_o matches the rsp_valid_o one-hot each time.
- Wrap-around: last_grant=2, req_valid_i=0011 -> grant 0. Then, with 0011 still high -> grant 1.
- Back-pressure:
  - Hold div_ready_i=0 for 5 cycles: div_valid_o stays high with stable operands; state stays ISSUE.
  - Then hold rsp_ready_i=0 for 4 cycles: rsp_valid_o stays high with stable results; req_ready_o stays 0 despite new requests.
- Signed op: a=-100, b=7, signed=1 -> div_signed_o=1. Divider result quot=-14, rem=-2 is returned unchanged.
- Reset during WAIT:
  - Assert rst_i for 1 cycle: all outputs go to 0, busy_o=0.
  - A late div_done_i is ignored.
  - Next request set 1010 -> grant 1.

Source files
------------

// File: rtl/mage_div_arbiter.sv
// Round-robin arbiter sharing one multi-cycle divider between NUM_REQ PEs.
// One operation in flight at a time; the result goes back over a valid/ready handshake.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | arbitrate; accept the winning request combinationally
// ISSUE    | present captured operands to the divider until accepted
// WAIT     | wait for the divider's done pulse, capture the result
// RESP     | present the result to the granted requester until taken
module mage_div_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_op_a_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_op_b_i,
  input  logic [NUM_REQ-1:0]               req_signed_i,
  output logic [NUM_REQ-1:0]               rsp_valid_o,
  input  logic [NUM_REQ-1:0]               rsp_ready_i,
  output logic [DATA_W-1:0]                rsp_quot_o,
  output logic [DATA_W-1:0]                rsp_rem_o,
  output logic                             div_valid_o,
  input  logic                             div_ready_i,
  output logic [DATA_W-1:0]                div_op_a_o,
  output logic [DATA_W-1:0]                div_op_b_o,
  output logic                             div_signed_o,
  input  logic                             div_done_i,
  input  logic [DATA_W-1:0]                div_quot_i,
  input  logic [DATA_W-1:0]                div_rem_i,
  output logic                             busy_o,
  output logic [ID_W-1:0]                  grant_id_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]      state;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] hi_idx;
  logic [ID_W-1:0] lo_idx;
  logic            hi_any;
  logic            lo_any;

  // Downward scan leaves the lowest set index; hi_* only sees bits above last_grant.
  always_comb begin
    hi_any = 1'b0;
    hi_idx = '0;
    lo_any = 1'b0;
    lo_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        lo_any = 1'b1;
        lo_idx = ID_W'(i);
        if (ID_W'(i) > last_grant) begin
          hi_any = 1'b1;
          hi_idx = ID_W'(i);
        end
      end
    end
    grant = hi_any ? hi_idx : lo_idx;
  end

  assign req_ready_o = (state == ST_IDLE && lo_any) ? (NUM_REQ'(1) << grant) : '0;
  assign rsp_valid_o = (state == ST_RESP) ? (NUM_REQ'(1) << grant_id_o) : '0;
  assign div_valid_o = (state == ST_ISSUE);
  assign busy_o      = (state != ST_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      last_grant   <= ID_W'(NUM_REQ - 1);
      grant_id_o   <= '0;
      div_op_a_o   <= '0;
      div_op_b_o   <= '0;
      div_signed_o <= 1'b0;
      rsp_quot_o   <= '0;
      rsp_rem_o    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (lo_any) begin
            grant_id_o   <= grant;
            div_op_a_o   <= req_op_a_i[grant];
            div_op_b_o   <= req_op_b_i[grant];
            div_signed_o <= req_signed_i[grant];
            state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (div_ready_i) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (div_done_i) begin
            rsp_quot_o <= div_quot_i;
            rsp_rem_o  <= div_rem_i;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i[grant_id_o]) begin
            last_grant <= grant_id_o;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mage_div_arbiter.sv
// Self-checking bench for mage_div_arbiter: directed scenarios plus randomized
// traffic checked against a scan-from-last-winner round-robin model.
module tb_mage_div_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic [N-1:0]         req_valid_i, req_ready_o, req_signed_i;
  logic [N-1:0][W-1:0]  req_op_a_i, req_op_b_i;
  logic [N-1:0]         rsp_valid_o, rsp_ready_i;
  logic [W-1:0]         rsp_quot_o, rsp_rem_o, div_op_a_o, div_op_b_o, div_quot_i, div_rem_i;
  logic                 div_valid_o, div_ready_i, div_signed_o, div_done_i, busy_o;
  logic [1:0]           grant_id_o;

  int errors = 0;
  int checks = 0;
  int model_last = N - 1;

  mage_div_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_a_i(req_op_a_i), .req_op_b_i(req_op_b_i), .req_signed_i(req_signed_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_quot_o(rsp_quot_o), .rsp_rem_o(rsp_rem_o),
    .div_valid_o(div_valid_o), .div_ready_i(div_ready_i),
    .div_op_a_o(div_op_a_o), .div_op_b_o(div_op_b_o), .div_signed_o(div_signed_o),
    .div_done_i(div_done_i), .div_quot_i(div_quot_i), .div_rem_i(div_rem_i),
    .busy_o(busy_o), .grant_id_o(grant_id_o)
  );

  always #5 clk_i = ~clk_i;

  // Next winner: first requester found scanning upward from the last winner, wrapping.
  function automatic int rr_pick(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic quiet_inputs;
    req_valid_i = '0; req_signed_i = '0; rsp_ready_i = '0;
    div_ready_i = 1'b0; div_done_i = 1'b0; div_quot_i = '0; div_rem_i = '0;
  endtask

  task automatic do_reset;
    rst_i = 1'b1;
    tick; tick;
    rst_i = 1'b0;
    model_last = N - 1;
  endtask

  // One full operation with fixed latencies; returns what was observed at each phase.
  task automatic run_txn(input logic [N-1:0] v, input int rdy_lat, input int done_lat,
                         input logic [W-1:0] q, input logic [W-1:0] r,
                         output logic [N-1:0] ready_seen, output logic [W-1:0] a_seen,
                         output logic [W-1:0] b_seen, output logic sgn_seen,
                         output logic [N-1:0] rv_seen, output logic [W-1:0] q_seen,
                         output logic [W-1:0] r_seen, output logic [1:0] gid_seen);
    req_valid_i = v;
    #1;
    ready_seen = req_ready_o;
    tick;
    div_ready_i = 1'b0;
    repeat (rdy_lat) tick;
    a_seen = div_op_a_o; b_seen = div_op_b_o; sgn_seen = div_signed_o;
    div_ready_i = 1'b1;
    tick;
    div_ready_i = 1'b0;
    repeat (done_lat) tick;
    div_done_i = 1'b1; div_quot_i = q; div_rem_i = r;
    tick;
    div_done_i = 1'b0; div_quot_i = $urandom; div_rem_i = $urandom;
    rsp_ready_i = '1;
    #1;
    rv_seen = rsp_valid_o; q_seen = rsp_quot_o; r_seen = rsp_rem_o; gid_seen = grant_id_o;
    tick;
    rsp_ready_i = '0;
  endtask

  task automatic test_reset;
    quiet_inputs();
    do_reset();
    #1;
    checks++; if (req_ready_o !== 4'b0) begin errors++; $display("FAIL reset_req_ready: got %b exp 0000", req_ready_o); end
    checks++; if (rsp_valid_o !== 4'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b exp 0000", rsp_valid_o); end
    checks++; if (div_valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL reset_div_valid_busy: got %b%b exp 00", div_valid_o, busy_o); end
    checks++; if (grant_id_o !== 2'd0 || rsp_quot_o !== '0 || div_op_a_o !== '0) begin
      errors++; $display("FAIL reset_regs: gid %0d quot %0h op_a %0h exp all 0", grant_id_o, rsp_quot_o, div_op_a_o); end
    tick; tick;
    checks++; if (busy_o !== 1'b0 || req_ready_o !== 4'b0) begin errors++; $display("FAIL idle_no_req: busy %b ready %b exp 0 0000", busy_o, req_ready_o); end
  endtask

  task automatic test_single;
    logic [N-1:0] rdy, rv; logic [W-1:0] a, b, q, r; logic s; logic [1:0] g;
    req_op_a_i[0] = 100; req_op_b_i[0] = 7; req_signed_i = '0;
    run_txn(4'b0001, 0, 2, 14, 2, rdy, a, b, s, rv, q, r, g);
    checks++; if (rdy !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b exp 0001", rdy); end
    checks++; if (a !== 100 || b !== 7) begin errors++; $display("FAIL single_ops: got %0d/%0d exp 100/7", a, b); end
    checks++; if (s !== 1'b0) begin errors++; $display("FAIL single_signed: got %b exp 0", s); end
    checks++; if (rv !== 4'b0001) begin errors++; $display("FAIL single_rsp_valid: got %b exp 0001", rv); end
    checks++; if (q !== 14 || r !== 2) begin errors++; $display("FAIL single_result: got %0d/%0d exp 14/2", q, r); end
    model_last = 0;
    req_valid_i = '0;
  endtask

  task automatic test_round_robin;
    logic [N-1:0] rdy, rv; logic [W-1:0] a, b, q, r; logic s; logic [1:0] g;
    int exp_g;
    quiet_inputs();
    do_reset();
    for (int i = 0; i < N; i++) begin req_op_a_i[i] = $urandom; req_op_b_i[i] = 32'(i + 1); end
    for (int n = 0; n < 5; n++) begin
      exp_g = rr_pick(model_last, 4'b1111);
      run_txn(4'b1111, 1, 1, 32'(n), 32'(n + 10), rdy, a, b, s, rv, q, r, g);
      checks++; if (rdy !== 4'(1 << exp_g) || g !== 2'(exp_g)) begin
        errors++; $display("FAIL rr_grant_%0d: ready %b gid %0d exp grant %0d", n, rdy, g, exp_g); end
      checks++; if (rv !== 4'(1 << g) || a !== req_op_a_i[exp_g]) begin
        errors++; $display("FAIL rr_rsp_%0d: rsp_valid %b op_a %0h exp onehot of %0d op_a %0h", n, rv, a, exp_g, req_op_a_i[exp_g]); end
      model_last = exp_g;
    end
    req_valid_i = '0;
  endtask

  task automatic test_wrap;
    logic [N-1:0] rdy, rv; logic [W-1:0] a, b, q, r; logic s; logic [1:0] g;
    int exp_g;
    logic [N-1:0] pats [3];
    pats[0] = 4'b0100; pats[1] = 4'b0011; pats[2] = 4'b0011;
    for (int n = 0; n < 3; n++) begin
      exp_g = rr_pick(model_last, pats[n]);
      run_txn(pats[n], 0, 0, 5, 6, rdy, a, b, s, rv, q, r, g);
      checks++; if (rdy !== 4'(1 << exp_g) || g !== 2'(exp_g)) begin
        errors++; $display("FAIL wrap_%0d: ready %b gid %0d exp grant %0d", n, rdy, g, exp_g); end
      model_last = exp_g;
    end
    req_valid_i = '0;
  endtask

  task automatic test_backpressure;
    logic [N-1:0] v; int exp_g; logic [W-1:0] ea, eb;
    v = 4'($urandom_range(1, 15));
    for (int i = 0; i < N; i++) begin req_op_a_i[i] = $urandom; req_op_b_i[i] = $urandom; end
    exp_g = rr_pick(model_last, v);
    ea = req_op_a_i[exp_g]; eb = req_op_b_i[exp_g];
    req_valid_i = v;
    tick;
    req_valid_i = '0;
    for (int i = 0; i < N; i++) begin req_op_a_i[i] = $urandom; req_op_b_i[i] = $urandom; end
    div_ready_i = 1'b0; div_done_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++; if (div_valid_o !== 1'b1 || busy_o !== 1'b1 || div_op_a_o !== ea || div_op_b_o !== eb) begin
        errors++; $display("FAIL bp_issue_%0d: valid %b busy %b ops %0h/%0h exp 1 1 %0h/%0h", c, div_valid_o, busy_o, div_op_a_o, div_op_b_o, ea, eb); end
      tick;
    end
    div_done_i = 1'b0;
    div_ready_i = 1'b1; tick; div_ready_i = 1'b0;
    div_done_i = 1'b1; div_quot_i = 32'h1234; div_rem_i = 32'h56; tick;
    div_done_i = 1'b0; div_quot_i = 32'hdead; div_rem_i = 32'hbeef;
    req_valid_i = '1;
    rsp_ready_i = ~(4'(1 << exp_g));
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (rsp_valid_o !== 4'(1 << exp_g) || rsp_quot_o !== 32'h1234 || rsp_rem_o !== 32'h56 || req_ready_o !== 4'b0) begin
        errors++; $display("FAIL bp_resp_%0d: rsp_valid %b res %0h/%0h req_ready %b exp grant %0d 1234/56 0000", c, rsp_valid_o, rsp_quot_o, rsp_rem_o, req_ready_o, exp_g); end
      tick;
    end
    req_valid_i = '0;
    rsp_ready_i = 4'(1 << exp_g);
    tick;
    rsp_ready_i = '0;
    #1;
    checks++; if (busy_o !== 1'b0 || rsp_quot_o !== 32'h1234 || grant_id_o !== 2'(exp_g)) begin
      errors++; $display("FAIL bp_after: busy %b quot %0h gid %0d exp 0 1234 %0d", busy_o, rsp_quot_o, grant_id_o, exp_g); end
    model_last = exp_g;
  endtask

  task automatic test_signed;
    logic [N-1:0] rdy, rv; logic [W-1:0] a, b, q, r; logic s; logic [1:0] g;
    logic [W-1:0] na, nq, nr;
    na = -100; nq = -14; nr = -2;
    req_op_a_i[2] = na; req_op_b_i[2] = 7; req_signed_i = 4'b0100;
    run_txn(4'b0100, 2, 0, nq, nr, rdy, a, b, s, rv, q, r, g);
    checks++; if (s !== 1'b1 || a !== na || b !== 7) begin errors++; $display("FAIL signed_issue: sgn %b ops %0h/%0h exp 1 %0h/7", s, a, b, na); end
    checks++; if (q !== nq || r !== nr || rv !== 4'b0100) begin errors++; $display("FAIL signed_result: %0h/%0h valid %b exp %0h/%0h 0100", q, r, rv, nq, nr); end
    model_last = 2;
    req_valid_i = '0; req_signed_i = '0;
  endtask

  task automatic test_reset_mid;
    logic [N-1:0] rdy, rv; logic [W-1:0] a, b, q, r; logic s; logic [1:0] g;
    req_valid_i = 4'b1000; tick;
    req_valid_i = '0;
    div_ready_i = 1'b1; tick; div_ready_i = 1'b0;
    rst_i = 1'b1; tick; rst_i = 1'b0;
    model_last = N - 1;
    #1;
    checks++; if (busy_o !== 1'b0 || div_valid_o !== 1'b0 || rsp_valid_o !== 4'b0 || req_ready_o !== 4'b0) begin
      errors++; $display("FAIL rstmid_ctrl: busy %b div_valid %b rsp_valid %b ready %b exp all 0", busy_o, div_valid_o, rsp_valid_o, req_ready_o); end
    checks++; if (grant_id_o !== 2'd0 || rsp_quot_o !== '0 || rsp_rem_o !== '0 || div_op_a_o !== '0 || div_op_b_o !== '0 || div_signed_o !== 1'b0) begin
      errors++; $display("FAIL rstmid_regs: gid %0d quot %0h rem %0h ops %0h/%0h sgn %b exp all 0", grant_id_o, rsp_quot_o, rsp_rem_o, div_op_a_o, div_op_b_o, div_signed_o); end
    div_done_i = 1'b1; div_quot_i = 32'h77; div_rem_i = 32'h88; tick;
    div_done_i = 1'b0;
    checks++; if (busy_o !== 1'b0 || rsp_valid_o !== 4'b0 || rsp_quot_o !== '0) begin
      errors++; $display("FAIL rstmid_late_done: busy %b rsp_valid %b quot %0h exp 0 0000 0", busy_o, rsp_valid_o, rsp_quot_o); end
    run_txn(4'b1010, 0, 1, 1, 1, rdy, a, b, s, rv, q, r, g);
    checks++; if (rdy !== 4'b0010 || g !== 2'd1 || rv !== 4'b0010) begin
      errors++; $display("FAIL rstmid_next_grant: ready %b gid %0d rsp_valid %b exp grant 1", rdy, g, rv); end
    model_last = 1;
    req_valid_i = '0;
  endtask

  task automatic test_random;
    logic [N-1:0] rdy, rv; logic [W-1:0] a, b, q, r; logic s; logic [1:0] g;
    logic [N-1:0] v; int exp_g; logic [W-1:0] eq, er;
    for (int n = 0; n < 30; n++) begin
      v = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        req_op_a_i[i] = $urandom; req_op_b_i[i] = 32'($urandom_range(1, 1000));
      end
      req_signed_i = 4'($urandom_range(0, 15));
      exp_g = rr_pick(model_last, v);
      eq = req_op_a_i[exp_g] / req_op_b_i[exp_g];
      er = req_op_a_i[exp_g] % req_op_b_i[exp_g];
      run_txn(v, $urandom_range(0, 3), $urandom_range(0, 3), eq, er, rdy, a, b, s, rv, q, r, g);
      checks++; if (rdy !== 4'(1 << exp_g) || g !== 2'(exp_g) || rv !== 4'(1 << exp_g)) begin
        errors++; $display("FAIL rand_grant_%0d: req %b ready %b gid %0d rsp_valid %b exp grant %0d", n, v, rdy, g, rv, exp_g); end
      checks++; if (a !== req_op_a_i[exp_g] || b !== req_op_b_i[exp_g] || s !== req_signed_i[exp_g] || q !== eq || r !== er) begin
        errors++; $display("FAIL rand_data_%0d: ops %0h/%0h sgn %b res %0h/%0h exp %0h/%0h %b %0h/%0h", n, a, b, s, q, r,
                           req_op_a_i[exp_g], req_op_b_i[exp_g], req_signed_i[exp_g], eq, er); end
      model_last = exp_g;
    end
    req_valid_i = '0;
  endtask

  initial begin
    rst_i = 1'b1;
    req_op_a_i = '0; req_op_b_i = '0;
    quiet_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_backpressure();
    test_signed();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
